cmd_frame_ctrl: RTL and testbench
=================================

CMD_FRAME_CTRL -- requirements
Module: cmd_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the RX byte, the register file data and the FIFO data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: register file address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum idle gap between bytes of one frame.
REQ-004 SHALL have port CLK, input, 1 bit: single clock, REF_CLK domain.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port rx_data, input, DATA_WIDTH: synchronised RX byte.
REQ-007 SHALL have port rx_valid, input, 1 bit: one-cycle byte strobe.
REQ-008 SHALL have the following register file ports:
- rf_addr, output, ADDR_WIDTH
- rf_wr_en, output, 1
- rf_rd_en, output, 1
- rf_wr_data, output, DATA_WIDTH
- rf_rd_data, input, DATA_WIDTH
- rf_rd_valid, input, 1
REQ-009 SHALL have the following ALU ports:
- alu_fun, output, 4
- alu_en, output, 1
- alu_gate_en, output, 1
- alu_out, input, 2*DATA_WIDTH
- alu_out_valid, input, 1
REQ-010 SHALL have the following FIFO ports:
- fifo_full, input, 1
- fifo_wr_inc, output, 1
- fifo_wr_data, output, DATA_WIDTH
REQ-011 SHALL have the following status ports, all output, 1 bit:
- clk_div_en
- busy: frame in progress
- frame_err: one-cycle error pulse

Function
REQ-012 SHALL decode opcodes:
- 0xAA: write (addr, data)
- 0xBB: read (addr)
- 0xCC: ALU with operands (A, B, fun)
- 0xDD: ALU without operands (fun)
- 0xEE: burst read (addr, count)
REQ-013 SHALL implement states IDLE, GET_ADDR, GET_DATA, GET_A, GET_B, GET_FUN, GET_CNT, RD_REQ, RD_WAIT, ALU_WAIT, PUSH.
REQ-014 SHALL, for an unknown opcode in IDLE, pulse frame_err for one cycle and remain in IDLE.
REQ-015 SHALL, on 0xAA, assert rf_wr_en for exactly one cycle, the cycle after the data byte, with the captured address and data.
REQ-016 SHALL, on 0xCC, write A to address 0 and B to address 1, each with a one-cycle rf_wr_en the cycle after that byte.
REQ-017 SHALL, on receipt of the fun byte, latch alu_fun, raise alu_gate_en and pulse alu_en one cycle later; alu_gate_en SHALL stay high until alu_out_valid.
REQ-018 SHALL push the ALU result as 2 bytes, LSB first.
REQ-019 SHALL, on a read, pulse rf_rd_en for one cycle, then wait for rf_rd_valid, then push rf_rd_data.
REQ-020 SHALL, on burst read, perform count sequential reads starting at addr; the address wraps modulo 2^ADDR_WIDTH; each read completes its push before the next rf_rd_en.
REQ-021 SHALL, when burst count = 0, perform no reads and no pushes and return to IDLE.
REQ-022 SHALL assert fifo_wr_inc only when fifo_full = 0, for one cycle per byte; fifo_wr_data SHALL be held stable until accepted.
REQ-023 SHALL, when rx_valid arrives in RD_REQ, RD_WAIT, ALU_WAIT or PUSH, drop the byte and pulse frame_err.
REQ-024 SHALL assert busy whenever the state is not IDLE.
REQ-025 SHALL hold clk_div_en = 1 whenever RST = 0.

Reset
REQ-026 SHALL, with RST = 1 sampled on a CLK edge, force IDLE and drive all outputs 0 (rf_addr, alu_fun and fifo_wr_data included).
REQ-027 SHALL, on reset mid-frame, abandon the frame with no further RF, ALU or FIFO activity.

Configuration
REQ-028 SHALL, with CMD_TIMEOUT_EN defined, count cycles without rx_valid in the GET_* states; when the count reaches TIMEOUT_CYCLES it SHALL return to IDLE and pulse frame_err.
REQ-029 SHALL, without CMD_TIMEOUT_EN, wait indefinitely in the GET_* states and contain no timeout counter.

Structure
REQ-030 SHALL take its opcode constants, state enum and ALU result byte-count constant from package cmd_frame_pkg.
REQ-031 SHALL instantiate sub-module cmd_frame_push, which serialises 1..N bytes into the FIFO under fifo_full backpressure.

Verification
REQ-032 SHALL cover write: AA,05,3C -> rf_wr_en one cycle with rf_addr = 5 and rf_wr_data = 0x3C; no FIFO write.
REQ-033 SHALL cover ALU with operands: CC,07,03,00 (add) -> writes reg0 = 07 and reg1 = 03, alu_en pulse, alu_out = 0x000A -> FIFO bytes 0A then 00.
REQ-034 SHALL cover burst wrap: EE,0E,03 -> reads addresses E, F, 0 in order -> 3 FIFO pushes.
REQ-035 SHALL cover backpressure: fifo_full held high for 10 cycles during a read -> no fifo_wr_inc and data stable, then exactly one push.
REQ-036 SHALL cover errors:
- opcode 0x55 -> frame_err pulse and busy stays 0.
- burst count 0 -> no pushes.
REQ-037 SHALL cover timeout: with CMD_TIMEOUT_EN, AA,05 followed by 255 idle cycles -> frame_err and return to IDLE.

Source files
------------

// File: rtl/cmd_frame_pkg.sv
// cmd_frame_pkg: opcode constants, FSM state and command encodings shared by
// the command-frame controller and its FIFO serialiser.
package cmd_frame_pkg;

   // Frame opcodes (first byte of every frame)
   localparam logic [7:0] OP_WRITE  = 8'hAA;
   localparam logic [7:0] OP_READ   = 8'hBB;
   localparam logic [7:0] OP_ALU_OP = 8'hCC;
   localparam logic [7:0] OP_ALU    = 8'hDD;
   localparam logic [7:0] OP_BURST  = 8'hEE;

   // ALU result is serialised as this many FIFO bytes, LSB first
   localparam int unsigned ALU_RES_BYTES = 2;
   localparam int unsigned PUSH_CNT_W    = $clog2(ALU_RES_BYTES + 1);

   typedef enum logic [3:0] {
      StIdle,
      StGetAddr,
      StGetData,
      StGetA,
      StGetB,
      StGetFun,
      StGetCnt,
      StRdReq,
      StRdWait,
      StAluWait,
      StPush
   } state_t;

   typedef enum logic [2:0] {
      CmdWrite,
      CmdRead,
      CmdAluOp,
      CmdAlu,
      CmdBurst
   } cmd_t;

endpackage

// File: rtl/cmd_frame_push.sv
// cmd_frame_push: serialises 1..ALU_RES_BYTES bytes (LSB first) into the FIFO,
// holding each byte stable on fifo_wr_data until fifo_full allows the write.
module cmd_frame_push
   import cmd_frame_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [ALU_RES_BYTES*DATA_WIDTH-1:0] data,
   input  logic [PUSH_CNT_W-1:0]               nbytes,
   input  logic                                fifo_full,
   output logic                                fifo_wr_inc,
   output logic [DATA_WIDTH-1:0]               fifo_wr_data,
   output logic                                done
);

   logic [ALU_RES_BYTES*DATA_WIDTH-1:0] shreg;
   logic [PUSH_CNT_W-1:0]               remaining;
   logic                                active;

   // Low byte of the shift register is the byte currently offered
   assign fifo_wr_data = shreg[DATA_WIDTH-1:0];
   assign fifo_wr_inc  = active & ~fifo_full;

   // Load on start, shift one byte out per accepted FIFO write
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg     <= '0;
         remaining <= '0;
         active    <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && !active) begin
            shreg     <= data;
            remaining <= nbytes;
            active    <= (nbytes != '0);
         end else if (fifo_wr_inc) begin
            shreg     <= shreg >> DATA_WIDTH;
            remaining <= remaining - PUSH_CNT_W'(1);
            if (remaining == PUSH_CNT_W'(1)) begin
               active <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cmd_frame_ctrl.sv
// cmd_frame_ctrl: decodes RX byte frames into register-file writes/reads,
// ALU operations and FIFO pushes of the results.
// Optional feature: define CMD_TIMEOUT_EN to abandon a frame after
// TIMEOUT_CYCLES idle cycles while collecting its bytes.
module cmd_frame_ctrl
   import cmd_frame_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   rx_data,
   input  logic                    rx_valid,
   output logic [ADDR_WIDTH-1:0]   rf_addr,
   output logic                    rf_wr_en,
   output logic                    rf_rd_en,
   output logic [DATA_WIDTH-1:0]   rf_wr_data,
   input  logic [DATA_WIDTH-1:0]   rf_rd_data,
   input  logic                    rf_rd_valid,
   output logic [3:0]              alu_fun,
   output logic                    alu_en,
   output logic                    alu_gate_en,
   input  logic [2*DATA_WIDTH-1:0] alu_out,
   input  logic                    alu_out_valid,
   input  logic                    fifo_full,
   output logic                    fifo_wr_inc,
   output logic [DATA_WIDTH-1:0]   fifo_wr_data,
   output logic                    clk_div_en,
   output logic                    busy,
   output logic                    frame_err
);

   localparam logic [DATA_WIDTH-1:0] OpWrite = DATA_WIDTH'(OP_WRITE);
   localparam logic [DATA_WIDTH-1:0] OpRead  = DATA_WIDTH'(OP_READ);
   localparam logic [DATA_WIDTH-1:0] OpAluOp = DATA_WIDTH'(OP_ALU_OP);
   localparam logic [DATA_WIDTH-1:0] OpAlu   = DATA_WIDTH'(OP_ALU);
   localparam logic [DATA_WIDTH-1:0] OpBurst = DATA_WIDTH'(OP_BURST);

   state_t                          state;
   cmd_t                            cmd;
   logic [DATA_WIDTH-1:0]           cnt;
   logic                            alu_started;
   logic                            push_start;
   logic [2*DATA_WIDTH-1:0]         push_data;
   logic [PUSH_CNT_W-1:0]           push_nbytes;
   logic                            push_done;

`ifdef CMD_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] idle_cnt;
`endif

   assign busy       = (state != StIdle);
   assign clk_div_en = ~RST;

   // Frame FSM with registered RF/ALU/push control outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= StIdle;
         cmd         <= CmdWrite;
         cnt         <= '0;
         rf_addr     <= '0;
         rf_wr_en    <= 1'b0;
         rf_rd_en    <= 1'b0;
         rf_wr_data  <= '0;
         alu_fun     <= '0;
         alu_en      <= 1'b0;
         alu_gate_en <= 1'b0;
         alu_started <= 1'b0;
         frame_err   <= 1'b0;
         push_start  <= 1'b0;
         push_data   <= '0;
         push_nbytes <= '0;
`ifdef CMD_TIMEOUT_EN
         idle_cnt    <= '0;
`endif
      end else begin
         rf_wr_en   <= 1'b0;
         rf_rd_en   <= 1'b0;
         alu_en     <= 1'b0;
         frame_err  <= 1'b0;
         push_start <= 1'b0;
         case (state)
            StIdle: if (rx_valid) begin
               case (rx_data)
                  OpWrite: begin cmd <= CmdWrite; state <= StGetAddr; end
                  OpRead:  begin
                     cmd   <= CmdRead;
                     cnt   <= DATA_WIDTH'(1);
                     state <= StGetAddr;
                  end
                  OpAluOp: begin cmd <= CmdAluOp; state <= StGetA; end
                  OpAlu:   begin cmd <= CmdAlu; state <= StGetFun; end
                  OpBurst: begin cmd <= CmdBurst; state <= StGetAddr; end
                  default: frame_err <= 1'b1;
               endcase
            end
            StGetAddr: if (rx_valid) begin
               rf_addr <= rx_data[ADDR_WIDTH-1:0];
               if (cmd == CmdWrite)      state <= StGetData;
               else if (cmd == CmdBurst) state <= StGetCnt;
               else                      state <= StRdReq;
            end
            StGetData: if (rx_valid) begin
               rf_wr_data <= rx_data;
               rf_wr_en   <= 1'b1;
               state      <= StIdle;
            end
            // Operands A and B land in registers 0 and 1
            StGetA: if (rx_valid) begin
               rf_addr    <= '0;
               rf_wr_data <= rx_data;
               rf_wr_en   <= 1'b1;
               state      <= StGetB;
            end
            StGetB: if (rx_valid) begin
               rf_addr    <= ADDR_WIDTH'(1);
               rf_wr_data <= rx_data;
               rf_wr_en   <= 1'b1;
               state      <= StGetFun;
            end
            StGetFun: if (rx_valid) begin
               alu_fun     <= rx_data[3:0];
               alu_gate_en <= 1'b1;
               alu_started <= 1'b0;
               state       <= StAluWait;
            end
            StGetCnt: if (rx_valid) begin
               cnt <= rx_data;
               if (rx_data == '0) state <= StIdle;
               else               state <= StRdReq;
            end
            StRdReq: begin
               rf_rd_en <= 1'b1;
               state    <= StRdWait;
            end
            StRdWait: if (rf_rd_valid) begin
               push_data   <= (2*DATA_WIDTH)'(rf_rd_data);
               push_nbytes <= PUSH_CNT_W'(1);
               push_start  <= 1'b1;
               state       <= StPush;
            end
            // alu_en fires one cycle after alu_fun/alu_gate_en become visible
            StAluWait: begin
               if (!alu_started) begin
                  alu_en      <= 1'b1;
                  alu_started <= 1'b1;
               end else if (alu_out_valid) begin
                  alu_gate_en <= 1'b0;
                  push_data   <= alu_out;
                  push_nbytes <= PUSH_CNT_W'(ALU_RES_BYTES);
                  push_start  <= 1'b1;
                  state       <= StPush;
               end
            end
            StPush: if (push_done) begin
               if ((cmd == CmdRead || cmd == CmdBurst) && cnt > DATA_WIDTH'(1)) begin
                  cnt     <= cnt - DATA_WIDTH'(1);
                  rf_addr <= rf_addr + ADDR_WIDTH'(1);
                  state   <= StRdReq;
               end else begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
         // Bytes arriving while the frame is executing are dropped
         if (rx_valid && state inside {StRdReq, StRdWait, StAluWait, StPush}) begin
            frame_err <= 1'b1;
         end
`ifdef CMD_TIMEOUT_EN
         if (!rx_valid && state inside {StGetAddr, StGetData, StGetA, StGetB, StGetFun,
                                        StGetCnt}) begin
            if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               idle_cnt  <= '0;
               state     <= StIdle;
               frame_err <= 1'b1;
            end else begin
               idle_cnt <= idle_cnt + TO_W'(1);
            end
         end else begin
            idle_cnt <= '0;
         end
`endif
      end
   end

   cmd_frame_push #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_push (
      .clk          (CLK),
      .rst          (RST),
      .start        (push_start),
      .data         (push_data),
      .nbytes       (push_nbytes),
      .fifo_full    (fifo_full),
      .fifo_wr_inc  (fifo_wr_inc),
      .fifo_wr_data (fifo_wr_data),
      .done         (push_done)
   );

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// tb_cmd_frame_ctrl: directed frames against simple RF/ALU/FIFO models.
module tb_cmd_frame_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic [AW-1:0] rf_addr;
   logic          rf_wr_en, rf_rd_en;
   logic [DW-1:0] rf_wr_data, rf_rd_data;
   logic          rf_rd_valid;
   logic [3:0]    alu_fun;
   logic          alu_en, alu_gate_en;
   logic [2*DW-1:0] alu_out;
   logic          alu_out_valid;
   logic          fifo_full, fifo_wr_inc;
   logic [DW-1:0] fifo_wr_data;
   logic          clk_div_en, busy, frame_err;

   always #5 CLK = ~CLK;

   cmd_frame_ctrl #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rf_addr       (rf_addr),
      .rf_wr_en      (rf_wr_en),
      .rf_rd_en      (rf_rd_en),
      .rf_wr_data    (rf_wr_data),
      .rf_rd_data    (rf_rd_data),
      .rf_rd_valid   (rf_rd_valid),
      .alu_fun       (alu_fun),
      .alu_en        (alu_en),
      .alu_gate_en   (alu_gate_en),
      .alu_out       (alu_out),
      .alu_out_valid (alu_out_valid),
      .fifo_full     (fifo_full),
      .fifo_wr_inc   (fifo_wr_inc),
      .fifo_wr_data  (fifo_wr_data),
      .clk_div_en    (clk_div_en),
      .busy          (busy),
      .frame_err     (frame_err)
   );

   // Register file model: one-cycle read latency
   logic [DW-1:0] rf_mem [16];
   always @(posedge CLK) begin
      if (RST) begin
         rf_rd_valid <= 1'b0;
         rf_rd_data  <= '0;
      end else begin
         rf_rd_valid <= rf_rd_en;
         if (rf_rd_en) rf_rd_data <= rf_mem[rf_addr];
         if (rf_wr_en) rf_mem[rf_addr] <= rf_wr_data;
      end
   end

   // ALU model: returns alu_rsp two cycles after alu_en
   logic [2*DW-1:0] alu_rsp;
   logic            alu_pipe;
   always @(posedge CLK) begin
      if (RST) begin
         alu_pipe      <= 1'b0;
         alu_out_valid <= 1'b0;
         alu_out       <= '0;
      end else begin
         alu_pipe      <= alu_en;
         alu_out_valid <= alu_pipe;
         if (alu_pipe) alu_out <= alu_rsp;
      end
   end

   // Monitor: logs every strobe cycle, sampled mid-cycle
   logic [AW+DW-1:0] wr_q [$];
   logic [AW-1:0]    rd_q [$];
   logic [DW-1:0]    ff_q [$];
   int n_err, n_alu_en, n_busy, n_full_push, n_gate_bad;
   always @(negedge CLK) begin
      if (!RST) begin
         if (rf_wr_en) wr_q.push_back({rf_addr, rf_wr_data});
         if (rf_rd_en) rd_q.push_back(rf_addr);
         if (fifo_wr_inc) ff_q.push_back(fifo_wr_data);
         if (fifo_wr_inc && fifo_full) n_full_push++;
         if (frame_err) n_err++;
         if (alu_en) n_alu_en++;
         if (alu_en && !alu_gate_en) n_gate_bad++;
         if (busy) n_busy++;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] wr_at(input int i);
      return (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] rd_at(input int i);
      return (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] ff_at(input int i);
      return (i < ff_q.size()) ? 32'(ff_q[i]) : 32'hFFFF_FFFF;
   endfunction

   task automatic clear_logs();
      wr_q.delete();
      rd_q.delete();
      ff_q.delete();
      n_err = 0; n_alu_en = 0; n_busy = 0; n_full_push = 0; n_gate_bad = 0;
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge CLK); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge CLK); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge CLK);
      while (busy && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check({tag, " idle"}, 32'(busy), 0);
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int stable_bad;
      rx_data = '0; rx_valid = 1'b0; fifo_full = 1'b0; alu_rsp = '0;
      clear_logs();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst busy", 32'(busy), 0);
      check("rst strobes", 32'({rf_wr_en, rf_rd_en, alu_en, alu_gate_en, fifo_wr_inc,
                               frame_err}), 0);
      check("rst rf_addr", 32'(rf_addr), 0);
      check("rst rf_wr_data", 32'(rf_wr_data), 0);
      check("rst alu_fun", 32'(alu_fun), 0);
      check("rst fifo_wr_data", 32'(fifo_wr_data), 0);
      check("rst clk_div_en", 32'(clk_div_en), 0);
      @(posedge CLK); #1; RST = 1'b0;
      @(negedge CLK);
      check("run clk_div_en", 32'(clk_div_en), 1);
      clear_logs();

      // Write AA,05,3C
      send(8'hAA);
      check("wr busy", 32'(busy), 1);
      send(8'h05);
      send(8'h3C);
      check("wr_en timing", 32'({rf_wr_en, rf_addr, rf_wr_data}), 32'h1_5_3C);
      wait_idle("wr");
      check("wr count", wr_q.size(), 1);
      check("wr entry", wr_at(0), 32'h53C);
      check("wr no fifo", ff_q.size(), 0);

      // ALU with operands CC,07,03,00 -> 0x000A
      clear_logs();
      alu_rsp = 16'h000A;
      send(8'hCC); send(8'h07); send(8'h03); send(8'h00);
      wait_idle("aluop");
      check("aluop wr count", wr_q.size(), 2);
      check("aluop wr0", wr_at(0), 32'h007);
      check("aluop wr1", wr_at(1), 32'h103);
      check("aluop alu_en count", n_alu_en, 1);
      check("aluop fifo count", ff_q.size(), 2);
      check("aluop fifo0", ff_at(0), 32'h0A);
      check("aluop fifo1", ff_at(1), 32'h00);
      check("aluop gate drop", 32'(alu_gate_en), 0);

      // ALU without operands DD,03 -> 0x1234
      clear_logs();
      alu_rsp = 16'h1234;
      send(8'hDD); send(8'h03);
      check("alu fun/gate", 32'({alu_gate_en, alu_en, alu_fun}), 32'h23);
      @(posedge CLK); #1;
      check("alu_en delayed", 32'(alu_en), 1);
      wait_idle("alu");
      check("alu fifo", {ff_at(0)[7:0], ff_at(1)[7:0], 16'(ff_q.size())}, 32'h3412_0002);
      check("alu no wr", wr_q.size(), 0);
      check("alu gate held", n_gate_bad, 0);

      // Burst wrap EE,0E,03 over E,F,0
      send(8'hAA); send(8'h0E); send(8'h11);
      send(8'hAA); send(8'h0F); send(8'h22);
      send(8'hAA); send(8'h00); send(8'h33);
      wait_idle("preload");
      clear_logs();
      send(8'hEE); send(8'h0E); send(8'h03);
      wait_idle("burst");
      check("burst rd count", rd_q.size(), 3);
      check("burst rd addrs", {rd_at(0)[7:0], rd_at(1)[7:0], rd_at(2)[7:0], 8'h0}, 32'h0E0F0000);
      check("burst fifo count", ff_q.size(), 3);
      check("burst fifo data", {ff_at(0)[7:0], ff_at(1)[7:0], ff_at(2)[7:0], 8'h0}, 32'h11223300);

      // Backpressure on a single read
      send(8'hAA); send(8'h03); send(8'h5A);
      wait_idle("bp preload");
      clear_logs();
      @(posedge CLK); #1; fifo_full = 1'b1;
      send(8'hBB); send(8'h03);
      repeat (5) @(negedge CLK);
      stable_bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (fifo_wr_data !== 8'h5A || fifo_wr_inc !== 1'b0) stable_bad++;
      end
      check("bp stable", stable_bad, 0);
      check("bp busy", 32'(busy), 1);
      check("bp no push", ff_q.size(), 0);
      @(posedge CLK); #1; fifo_full = 1'b0;
      wait_idle("bp");
      check("bp one push", ff_q.size(), 1);
      check("bp data", ff_at(0), 32'h5A);
      check("bp full push", n_full_push, 0);

      // Unknown opcode
      clear_logs();
      send(8'h55);
      check("badop err", 32'(frame_err), 1);
      repeat (3) @(negedge CLK);
      check("badop err count", n_err, 1);
      check("badop busy", n_busy, 0);

      // Burst count zero
      clear_logs();
      send(8'hEE); send(8'h02); send(8'h00);
      wait_idle("burst0");
      check("burst0 no rd/push", rd_q.size() + ff_q.size(), 0);

      // Byte during read execution is dropped
      clear_logs();
      send(8'hBB); send(8'h03); send(8'h77);
      wait_idle("drop");
      check("drop err", n_err, 1);
      check("drop push", {24'(ff_q.size()), ff_at(0)[7:0]}, 32'h0000_015A);

      // Reset mid-frame
      clear_logs();
      send(8'hAA); send(8'h09);
      @(posedge CLK); #1; RST = 1'b1;
      @(posedge CLK); #1; RST = 1'b0;
      @(negedge CLK);
      check("midrst busy", 32'(busy), 0);
      send(8'h3C);
      repeat (5) @(negedge CLK);
      check("midrst no wr", wr_q.size(), 0);
      check("midrst 3C is bad op", n_err, 1);

      // Idle gap inside a frame
      clear_logs();
      send(8'hAA); send(8'h05);
`ifdef CMD_TIMEOUT_EN
      repeat (250) @(negedge CLK);
      check("to not yet", 32'(busy), 1);
      repeat (10) @(negedge CLK);
      check("to idle", 32'(busy), 0);
      check("to err", n_err, 1);
      check("to no wr", wr_q.size(), 0);
`else
      repeat (300) @(negedge CLK);
      check("no-to busy", 32'(busy), 1);
      check("no-to err", n_err, 0);
      send(8'h3C);
      wait_idle("no-to");
      check("no-to wr", wr_at(0), 32'h53C);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
